io_output_buffer: RTL and testbench
===================================

Name: io_output_buffer

Overview:
Memory-mapped console/output byte FIFO inside the Hubris core, on the producer side of the io_output_* interface. The CPU writes bytes through store instructions to a DATA register. The bench or external consumer drains them through io_output_en, io_output_data and io_buffer_size_avai. It also exposes STATUS and CTRL registers, so software can poll occupancy, detect overflow and flush the FIFO.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, 2..32768
BASE_ADDR, 32'hFFFF_0000, MMIO base; 16-byte aligned

Ports:
clk  in  1  core clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
mmio_addr  in  32  byte address from the load/store unit
mmio_wr_en  in  1  store strobe, one cycle per store
mmio_wr_data  in  32  store data
mmio_byte_en  in  4  store byte enables
mmio_rd_en  in  1  load strobe
mmio_rd_data  out  32  load data, registered
io_output_en  in  1  consumer pop request
io_output_data  out  8  byte at FIFO head (show-ahead)
io_buffer_size_avai  out  32  current occupancy, zero-extended

Behaviour:
- Decode: hit when mmio_addr[31:4] == BASE_ADDR[31:4]. Offset is mmio_addr[3:2]: 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved. mmio_addr[1:0] is ignored.
- Reset (reset == 0, asynchronous): count = 0, read/write pointers = 0, overflow = 0, mmio_rd_data = 0. Storage contents are not reset. io_output_data is undefined while count == 0.
- Push: write to DATA with mmio_byte_en[0] = 1 pushes mmio_wr_data[7:0] on the next posedge. Data becomes visible at the head on the following cycle if the FIFO was empty.
- Push with byte_en[0] = 0 does nothing.
- Pop: on posedge, when io_output_en == 1 and count > 0, advance the read pointer. io_output_data is taken combinationally from storage[rd_ptr], so the consumer samples the byte on the same edge it pops.
- Pop when count == 0 is ignored, with no underflow.
- io_buffer_size_avai = count; it updates the cycle after each push or pop.
- Full: count == DEPTH.
  - Push while full and no pop: the byte is dropped and overflow is set (sticky).
  - Push and pop on the same edge while full: both take effect; count stays DEPTH and no overflow.
- Empty with simultaneous push and pop: the pop is ignored (no bypass) and count becomes 1.
- Push and pop on the same edge while not full and not empty: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count width is log2(DEPTH) + 1 bits.
- CTRL write with byte_en[0]:
  - bit0 = 1 flushes: count = 0 and rd_ptr = wr_ptr.
  - bit1 = 1 clears overflow.
  - Flush dominates any push or pop on the same edge; those are dropped.
- Read: mmio_rd_en with a hit registers mmio_rd_data on the next posedge (1-cycle load latency):
  - DATA reads 0.
  - STATUS = {overflow[31], 13'b0, empty[17], full[16], count zero-extended to 16 bits in [15:0]}.
  - CTRL and reserved offsets read 0.
  - No hit, or mmio_rd_en = 0, drives 0 on mmio_rd_data for that cycle.
- Simultaneous read of STATUS and push/pop on the same edge: STATUS returns the pre-edge state.
- Reset asserted mid-operation discards all queued bytes immediately (asynchronous clear).

Decomposition:
- Shared package hubris_io_pkg:
  - offset constants IO_OFF_DATA, IO_OFF_STATUS, IO_OFF_CTRL
  - STATUS bit positions IO_ST_OVERFLOW, IO_ST_FULL, IO_ST_EMPTY
  - CTRL bit positions IO_CTRL_FLUSH, IO_CTRL_CLR_OVF
- One sub-module, io_byte_fifo:
  - parameters DEPTH and WIDTH = 8
  - ports: push, push_data, pop, flush, head_data, count, full, empty
  - show-ahead read; same full/empty simultaneity rules as above
- io_output_buffer holds the MMIO decode, the overflow flag and the read-data register.

Test Plan:
- Reset then idle -> io_buffer_size_avai = 0; STATUS read returns 32'h0002_0000 (empty).
- Store 8'h48 then 8'h69 to DATA with io_output_en = 0 -> count = 2, io_output_data = 8'h48. Raise io_output_en -> bytes 8'h48 then 8'h69 popped on consecutive edges, count returns to 0, and further pops are ignored.
- Push 17 bytes (0x00..0x10) with DEPTH = 16 and no pop -> count = 16, STATUS = 32'h8001_0010, byte 0x10 dropped; draining yields 0x00..0x0F in order.
- Full FIFO with push and pop on the same edge -> count stays 16, overflow stays 0, and the new byte is returned last; pointer wrap verified over 40 such pushes.
- Write CTRL = 32'h3 with 5 bytes queued, while a simultaneous pop request is active -> count = 0 next cycle, overflow cleared, nothing consumed.
- Assert reset low mid-drain (asynchronously, between edges) -> io_buffer_size_avai = 0 immediately and mmio_rd_data = 0; after release, a new push of 8'hA5 is the first byte out.

Source files
------------

// File: rtl/hubris_io_pkg.sv
// Shared definitions for the Hubris console output block.
//   io_off_e       : register offsets taken from mmio_addr[3:2]
//   IO_ST_*        : bit positions inside the STATUS word
//   IO_CTRL_*      : bit positions inside the CTRL word
//   io_status_word : packs the STATUS register from its fields
package hubris_io_pkg;

  typedef enum logic [1:0] {
    IO_OFF_DATA   = 2'd0,
    IO_OFF_STATUS = 2'd1,
    IO_OFF_CTRL   = 2'd2,
    IO_OFF_RSVD   = 2'd3
  } io_off_e;

  localparam int unsigned IO_ST_OVERFLOW = 31;
  localparam int unsigned IO_ST_EMPTY    = 17;
  localparam int unsigned IO_ST_FULL     = 16;

  localparam int unsigned IO_CTRL_FLUSH   = 0;
  localparam int unsigned IO_CTRL_CLR_OVF = 1;

  // STATUS = {overflow, 13'b0, empty, full, count[15:0]}
  function automatic logic [31:0] io_status_word(input logic        ovf,
                                                 input logic        empty,
                                                 input logic        full,
                                                 input logic [15:0] count);
    logic [31:0] w;
    w                 = '0;
    w[IO_ST_OVERFLOW] = ovf;
    w[IO_ST_EMPTY]    = empty;
    w[IO_ST_FULL]     = full;
    w[15:0]           = count;
    return w;
  endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Show-ahead byte FIFO used by io_output_buffer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push       : write push_data this edge (ignored when full without pop)
//   push_data  : byte to enqueue
//   pop        : advance the head this edge (ignored when empty)
//   flush      : drop all contents; dominates push and pop
//   head_data  : storage[rd_ptr], valid only while !empty
//   count      : occupancy, $clog2(DEPTH)+1 bits
//   full/empty : count == DEPTH / count == 0
module io_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_COUNT);
    // A pop on a full FIFO frees the slot the simultaneous push lands in;
    // on an empty FIFO the pop is refused, so there is no bypass path.
    do_pop  = pop && !empty && !flush;
    do_push = push && !flush && (!full || do_pop);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/io_output_buffer.sv
// Memory-mapped console output FIFO (producer side of io_output_*).
//   clk                 : core clock
//   reset               : asynchronous active-low reset
//   mmio_addr           : load/store byte address; hit on [31:4] == BASE_ADDR[31:4]
//   mmio_wr_en          : store strobe
//   mmio_wr_data        : store data (DATA uses [7:0], CTRL uses [1:0])
//   mmio_byte_en        : store byte enables; only [0] is honoured
//   mmio_rd_en          : load strobe
//   mmio_rd_data        : registered load data (1-cycle latency)
//   io_output_en        : consumer pop request
//   io_output_data      : byte at FIFO head (show-ahead)
//   io_buffer_size_avai : occupancy, zero-extended
// Registers: DATA (+0, write pushes), STATUS (+4), CTRL (+8, flush/clear overflow).
module io_output_buffer
  import hubris_io_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mmio_addr,
  input  logic        mmio_wr_en,
  input  logic [31:0] mmio_wr_data,
  input  logic [3:0]  mmio_byte_en,
  input  logic        mmio_rd_en,
  output logic [31:0] mmio_rd_data,
  input  logic        io_output_en,
  output logic [7:0]  io_output_data,
  output logic [31:0] io_buffer_size_avai
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          hit;
  io_off_e       off;
  logic          data_wr, ctrl_wr;
  logic          flush, clr_ovf;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ovf_q, ovf_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          unused_bits;

  always_comb begin
    hit     = (mmio_addr[31:4] == BASE_ADDR[31:4]);
    off     = io_off_e'(mmio_addr[3:2]);
    data_wr = mmio_wr_en && hit && (off == IO_OFF_DATA) && mmio_byte_en[0];
    ctrl_wr = mmio_wr_en && hit && (off == IO_OFF_CTRL) && mmio_byte_en[0];
    flush   = ctrl_wr && mmio_wr_data[IO_CTRL_FLUSH];
    clr_ovf = ctrl_wr && mmio_wr_data[IO_CTRL_CLR_OVF];
  end

  io_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (data_wr),
    .push_data (mmio_wr_data[7:0]),
    .pop       (io_output_en),
    .flush     (flush),
    .head_data (io_output_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A store into a full FIFO is lost only when no pop frees a slot on the
  // same edge (a full FIFO is never empty, so io_output_en always pops).
  always_comb begin
    ovf_d = ovf_q;
    if (data_wr && fifo_full && !io_output_en) ovf_d = 1'b1;
    if (clr_ovf) ovf_d = 1'b0;
  end

  // STATUS is built from pre-edge state, so a read racing a push/pop
  // returns the occupancy before that edge.
  always_comb begin
    rd_data_d = '0;
    if (mmio_rd_en && hit) begin
      case (off)
        IO_OFF_STATUS: rd_data_d = io_status_word(ovf_q, fifo_empty, fifo_full,
                                                  16'(fifo_count));
        default:       rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign mmio_rd_data        = rd_data_q;
  assign io_buffer_size_avai = 32'(fifo_count);

  assign unused_bits = ^{mmio_addr[1:0], mmio_wr_data[31:8], mmio_wr_data[7:2],
                         mmio_byte_en[3:1]};

endmodule

// File: tb/tb_io_output_buffer.sv
module tb_io_output_buffer;

  localparam logic [31:0] A_DATA   = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0008;
  localparam logic [31:0] A_MISS   = 32'hFFFE_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mmio_addr = '0;
  logic        mmio_wr_en = 1'b0;
  logic [31:0] mmio_wr_data = '0;
  logic [3:0]  mmio_byte_en = '0;
  logic        mmio_rd_en = 1'b0;
  logic [31:0] mmio_rd_data;
  logic        io_output_en = 1'b0;
  logic [7:0]  io_output_data;
  logic [31:0] io_buffer_size_avai;

  int errors = 0;
  int checks = 0;

  io_output_buffer #(
    .DEPTH     (16),
    .BASE_ADDR (32'hFFFF_0000)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .mmio_addr           (mmio_addr),
    .mmio_wr_en          (mmio_wr_en),
    .mmio_wr_data        (mmio_wr_data),
    .mmio_byte_en        (mmio_byte_en),
    .mmio_rd_en          (mmio_rd_en),
    .mmio_rd_data        (mmio_rd_data),
    .io_output_en        (io_output_en),
    .io_output_data      (io_output_data),
    .io_buffer_size_avai (io_buffer_size_avai)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
    mmio_addr    = addr;
    mmio_wr_data = data;
    mmio_byte_en = be;
    mmio_wr_en   = 1'b1;
    tick();
    mmio_wr_en   = 1'b0;
    mmio_byte_en = '0;
  endtask

  task automatic mmio_read(input logic [31:0] addr, output logic [31:0] data);
    mmio_addr  = addr;
    mmio_rd_en = 1'b1;
    tick();
    mmio_rd_en = 1'b0;
    data       = mmio_rd_data;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #2;
    checks++;
    if (io_buffer_size_avai !== 32'd0) begin
      errors++; $display("FAIL reset_size: got %h expected %h", io_buffer_size_avai, 32'd0);
    end
    checks++;
    if (mmio_rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_rd_data: got %h expected %h", mmio_rd_data, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    mmio_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0002_0000) begin
      errors++; $display("FAIL reset_status: got %h expected %h", r, 32'h0002_0000);
    end
    mmio_read(A_MISS, r);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL miss_read: got %h expected %h", r, 32'h0);
    end
  endtask

  task automatic test_push_pop();
    mmio_write(A_DATA, 32'hFFFF_FF48, 4'h1);
    mmio_write(A_DATA, 32'h0000_0069, 4'hF);
    mmio_write(A_DATA, 32'h0000_0077, 4'hE);
    checks++;
    if (io_buffer_size_avai !== 32'd2) begin
      errors++; $display("FAIL pp_count: got %0d expected 2", io_buffer_size_avai);
    end
    checks++;
    if (io_output_data !== 8'h48) begin
      errors++; $display("FAIL pp_head0: got %h expected 48", io_output_data);
    end
    io_output_en = 1'b1;
    tick();
    checks++;
    if (io_output_data !== 8'h69 || io_buffer_size_avai !== 32'd1) begin
      errors++; $display("FAIL pp_head1: got %h/%0d expected 69/1", io_output_data, io_buffer_size_avai);
    end
    tick();
    checks++;
    if (io_buffer_size_avai !== 32'd0) begin
      errors++; $display("FAIL pp_empty: got %0d expected 0", io_buffer_size_avai);
    end
    tick();
    tick();
    checks++;
    if (io_buffer_size_avai !== 32'd0) begin
      errors++; $display("FAIL pp_underflow: got %0d expected 0", io_buffer_size_avai);
    end
    io_output_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    for (int unsigned i = 0; i <= 16; i++) mmio_write(A_DATA, i, 4'h1);
    checks++;
    if (io_buffer_size_avai !== 32'd16) begin
      errors++; $display("FAIL ovf_count: got %0d expected 16", io_buffer_size_avai);
    end
    mmio_read(A_STATUS, r);
    checks++;
    if (r !== 32'h8001_0010) begin
      errors++; $display("FAIL ovf_status: got %h expected %h", r, 32'h8001_0010);
    end
    io_output_en = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      checks++;
      if (io_output_data !== 8'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, io_output_data, 8'(i));
      end
      tick();
    end
    io_output_en = 1'b0;
    mmio_read(A_STATUS, r);
    checks++;
    if (r !== 32'h8002_0000) begin
      errors++; $display("FAIL ovf_sticky: got %h expected %h", r, 32'h8002_0000);
    end
    mmio_write(A_CTRL, 32'h2, 4'h1);
    mmio_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0002_0000) begin
      errors++; $display("FAIL ovf_clear: got %h expected %h", r, 32'h0002_0000);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0]  q[$];
    logic [7:0]  exp;
    logic [31:0] r;
    for (int unsigned i = 0; i < 16; i++) begin
      mmio_write(A_DATA, 32'h20 + i, 4'h1);
      q.push_back(8'(32'h20 + i));
    end
    io_output_en = 1'b1;
    for (int unsigned k = 0; k < 40; k++) begin
      exp = q.pop_front();
      checks++;
      if (io_output_data !== exp) begin
        errors++; $display("FAIL full_pp_head[%0d]: got %h expected %h", k, io_output_data, exp);
      end
      q.push_back(8'(32'h80 + k));
      mmio_write(A_DATA, 32'h80 + k, 4'h1);
      if (io_buffer_size_avai !== 32'd16) begin
        checks++; errors++;
        $display("FAIL full_pp_count[%0d]: got %0d expected 16", k, io_buffer_size_avai);
      end
    end
    io_output_en = 1'b0;
    mmio_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0001_0010) begin
      errors++; $display("FAIL full_pp_status: got %h expected %h", r, 32'h0001_0010);
    end
    io_output_en = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      exp = 8'(32'h98 + i);
      checks++;
      if (io_output_data !== exp) begin
        errors++; $display("FAIL full_pp_drain[%0d]: got %h expected %h", i, io_output_data, exp);
      end
      if (i == 15) begin
        checks++;
        if (io_output_data !== 8'hA7) begin
          errors++; $display("FAIL full_pp_last: got %h expected a7", io_output_data);
        end
      end
      tick();
    end
    io_output_en = 1'b0;
    checks++;
    if (io_buffer_size_avai !== 32'd0) begin
      errors++; $display("FAIL full_pp_empty: got %0d expected 0", io_buffer_size_avai);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    for (int unsigned i = 0; i < 17; i++) mmio_write(A_DATA, 32'h40 + i, 4'h1);
    io_output_en = 1'b1;
    repeat (11) tick();
    io_output_en = 1'b0;
    checks++;
    if (io_buffer_size_avai !== 32'd5) begin
      errors++; $display("FAIL flush_pre: got %0d expected 5", io_buffer_size_avai);
    end
    io_output_en = 1'b1;
    mmio_write(A_CTRL, 32'h3, 4'h1);
    io_output_en = 1'b0;
    checks++;
    if (io_buffer_size_avai !== 32'd0) begin
      errors++; $display("FAIL flush_count: got %0d expected 0", io_buffer_size_avai);
    end
    mmio_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0002_0000) begin
      errors++; $display("FAIL flush_status: got %h expected %h", r, 32'h0002_0000);
    end
    mmio_write(A_DATA, 32'h5A, 4'h1);
    checks++;
    if (io_output_data !== 8'h5A || io_buffer_size_avai !== 32'd1) begin
      errors++; $display("FAIL flush_repush: got %h/%0d expected 5a/1", io_output_data, io_buffer_size_avai);
    end
    // STATUS read racing a pop reports the pre-edge count.
    io_output_en = 1'b1;
    mmio_read(A_STATUS, r);
    io_output_en = 1'b0;
    checks++;
    if (r !== 32'h0000_0001 || io_buffer_size_avai !== 32'd0) begin
      errors++; $display("FAIL status_pre_edge: got %h/%0d expected 00000001/0", r, io_buffer_size_avai);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    for (int unsigned i = 0; i < 4; i++) mmio_write(A_DATA, 32'hC0 + i, 4'h1);
    io_output_en = 1'b1;
    mmio_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0000_0004 || io_buffer_size_avai !== 32'd3) begin
      errors++; $display("FAIL rst_pre: got %h/%0d expected 00000004/3", r, io_buffer_size_avai);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (io_buffer_size_avai !== 32'd0 || mmio_rd_data !== 32'd0) begin
      errors++; $display("FAIL rst_async: got %0d/%h expected 0/00000000", io_buffer_size_avai, mmio_rd_data);
    end
    io_output_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    mmio_write(A_DATA, 32'hA5, 4'h1);
    checks++;
    if (io_output_data !== 8'hA5 || io_buffer_size_avai !== 32'd1) begin
      errors++; $display("FAIL rst_first: got %h/%0d expected a5/1", io_output_data, io_buffer_size_avai);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
